// File: rtl/fetch_mem_if_if.sv
// Bus bundle for fetch_mem_if: fetch-unit request/response plus the halfword
// instruction-memory read port.
interface fetch_mem_if_if;
  logic        fetch_req;
  logic [15:0] pc_in;
  logic        flush;
  logic        mem_rd;
  logic [15:0] mem_addr;
  logic [15:0] mem_data;
  logic        mem_ready;
  logic [31:0] fetch_opc;
  logic        opc_valid;
  logic        hold;

  modport slave (
    input  fetch_req, pc_in, flush, mem_data, mem_ready,
    output mem_rd, mem_addr, fetch_opc, opc_valid, hold
  );

  modport master (
    output fetch_req, pc_in, flush, mem_data, mem_ready,
    input  mem_rd, mem_addr, fetch_opc, opc_valid, hold
  );
endinterface

// File: rtl/fetch_mem_if.sv
// Fetches a 32-bit instruction as two halfword reads (high half first).
// Optional last-word hit path: define FETCH_MEM_IF_LASTWORD_HIT_EN.
module fetch_mem_if (
  input  logic           clk,
  input  logic           a_rst,
  fetch_mem_if_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RD_HI = 2'b01,
    RD_LO = 2'b10
  } state_t;

  state_t      state_q;
  logic [13:0] addr_q;
  logic [31:0] fetch_opc_q;
  logic        opc_valid_q;
  logic        mem_rd_q;
  logic [15:0] mem_addr_q;
  logic        hit;
  logic        done;
  logic        unused_pc_lsb;

  assign unused_pc_lsb = ^bus.pc_in[1:0];
  assign done = (state_q == RD_LO) && bus.mem_ready && !bus.flush;

`ifdef FETCH_MEM_IF_LASTWORD_HIT_EN
  logic [13:0] tag_q;
  logic        tag_valid_q;

  assign hit = bus.fetch_req && !bus.flush && tag_valid_q &&
               (bus.pc_in[15:2] == tag_q) && (state_q == IDLE);

  always_ff @(posedge clk or negedge a_rst) begin
    if (!a_rst) begin
      tag_q       <= '0;
      tag_valid_q <= 1'b0;
    end else if (bus.flush) begin
      tag_valid_q <= 1'b0;
    end else if (done) begin
      tag_q       <= addr_q;
      tag_valid_q <= 1'b1;
    end
  end
`else
  assign hit = 1'b0;
`endif

  // mem_rd/mem_addr are registered, so each transition loads the value the
  // destination state must present.
  always_ff @(posedge clk or negedge a_rst) begin
    if (!a_rst) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      fetch_opc_q <= '0;
      opc_valid_q <= 1'b0;
      mem_rd_q    <= 1'b0;
      mem_addr_q  <= '0;
    end else begin
      opc_valid_q <= 1'b0;
      if (bus.flush) begin
        state_q    <= IDLE;
        mem_rd_q   <= 1'b0;
        mem_addr_q <= {addr_q, 2'b00};
      end else begin
        case (state_q)
          IDLE: begin
            if (bus.fetch_req) begin
              if (hit) begin
                opc_valid_q <= 1'b1;
              end else begin
                addr_q     <= bus.pc_in[15:2];
                state_q    <= RD_HI;
                mem_rd_q   <= 1'b1;
                mem_addr_q <= {bus.pc_in[15:2], 2'b00};
              end
            end
          end
          RD_HI: begin
            if (bus.mem_ready) begin
              fetch_opc_q[31:16] <= bus.mem_data;
              state_q            <= RD_LO;
              mem_addr_q         <= {addr_q, 2'b10};
            end
          end
          RD_LO: begin
            if (bus.mem_ready) begin
              fetch_opc_q[15:0] <= bus.mem_data;
              state_q           <= IDLE;
              mem_rd_q          <= 1'b0;
              mem_addr_q        <= {addr_q, 2'b00};
              opc_valid_q       <= 1'b1;
            end
          end
          default: begin
            state_q    <= IDLE;
            mem_rd_q   <= 1'b0;
            mem_addr_q <= {addr_q, 2'b00};
          end
        endcase
      end
    end
  end

  assign bus.mem_rd    = mem_rd_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.fetch_opc = fetch_opc_q;
  assign bus.opc_valid = opc_valid_q;
  assign bus.hold      = (state_q != IDLE) || (bus.fetch_req && !hit);

endmodule

// File: tb/tb_fetch_mem_if.sv
// Randomized and directed bench for fetch_mem_if against a transaction-level
// model of the two-halfword fetch, flush and optional last-word hit.
module tb_fetch_mem_if;

  logic clk;
  logic a_rst;
  fetch_mem_if_if bus ();

  fetch_mem_if dut (
    .clk   (clk),
    .a_rst (a_rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    logic [15:0] t;
    if (a == 16'h0010) return 16'hA9C0;
    if (a == 16'h0012) return 16'h1234;
    t = a * 16'h0F3B;
    return t ^ 16'hC35A;
  endfunction

  assign bus.mem_data = mem_word(bus.mem_addr);

`ifdef FETCH_MEM_IF_LASTWORD_HIT_EN
  localparam bit HIT_EN = 1'b1;
`else
  localparam bit HIT_EN = 1'b0;
`endif

  int unsigned n_vec  = 0;
  int unsigned n_miss = 0;
  int unsigned rd_cnt = 0;
  bit          saw_zero = 1'b0;

  // reference model: a pending fetch is just an address and how many halves are in
  bit          m_busy;
  int unsigned m_halves;
  logic [13:0] m_addr;
  logic [31:0] m_opc;
  bit          m_valid;
  logic [13:0] m_tag;
  bit          m_tagv;
  bit          m_opc_chk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_halves = 0; m_addr = '0; m_opc = '0;
    m_valid = 0; m_tag = '0; m_tagv = 0; m_opc_chk = 1;
  endtask

  task automatic do_reset();
    bus.fetch_req = 1'b0; bus.pc_in = '0; bus.flush = 1'b0; bus.mem_ready = 1'b0;
    a_rst = 1'b0;
    #2;
    chk("rst_mem_rd",    {31'd0, bus.mem_rd},    32'd0);
    chk("rst_mem_addr",  {16'd0, bus.mem_addr},  32'd0);
    chk("rst_opc_valid", {31'd0, bus.opc_valid}, 32'd0);
    chk("rst_fetch_opc", bus.fetch_opc,          32'd0);
    chk("rst_hold",      {31'd0, bus.hold},      32'd0);
    model_reset();
    @(posedge clk);
    #1 a_rst = 1'b1;
  endtask

  // apply one cycle of inputs, compare outputs mid-cycle, advance the model at the edge
  task automatic cycle(input bit fr, input logic [15:0] pc, input bit fl, input bit rdy);
    bit          hit;
    logic [15:0] exp_addr;
    bus.fetch_req = fr; bus.pc_in = pc; bus.flush = fl; bus.mem_ready = rdy;
    hit = HIT_EN && !m_busy && fr && !fl && m_tagv && (pc[15:2] == m_tag);
    exp_addr = {m_addr, (m_busy && m_halves == 1), 1'b0};
    @(negedge clk);
    chk("mem_rd",    {31'd0, bus.mem_rd},    {31'd0, m_busy});
    chk("mem_addr",  {16'd0, bus.mem_addr},  {16'd0, exp_addr});
    chk("hold",      {31'd0, bus.hold},      {31'd0, m_busy || (fr && !hit)});
    chk("opc_valid", {31'd0, bus.opc_valid}, {31'd0, m_valid});
    if (m_valid || m_opc_chk) chk("fetch_opc", bus.fetch_opc, m_opc);
    if (bus.mem_rd && bus.mem_ready) rd_cnt++;
    if (bus.mem_rd && bus.mem_addr == 16'h0000) saw_zero = 1'b1;
    @(posedge clk);
    m_valid = 0;
    if (fl) begin
      if (m_busy) m_opc_chk = 0;
      m_busy = 0;
      m_tagv = 0;
    end else if (m_busy) begin
      if (rdy) begin
        if (m_halves == 0) begin
          m_opc[31:16] = mem_word({m_addr, 2'b00});
          m_halves = 1;
        end else begin
          m_opc[15:0] = mem_word({m_addr, 2'b10});
          m_busy = 0; m_valid = 1; m_opc_chk = 1;
          m_tag = m_addr; m_tagv = 1;
        end
      end
    end else if (fr) begin
      if (hit) m_valid = 1;
      else begin
        m_busy = 1; m_halves = 0; m_addr = pc[15:2];
      end
    end
    #1;
  endtask

  task automatic idle(input int unsigned n, input bit rdy);
    for (int unsigned i = 0; i < n; i++) cycle(1'b0, 16'h0000, 1'b0, rdy);
  endtask

  initial begin
    a_rst = 1'b0;
    do_reset();

    // zero-wait fetch of 0x0010
    rd_cnt = 0;
    cycle(1'b1, 16'h0010, 1'b0, 1'b1);
    idle(3, 1'b1);
    chk("fetch_0010_reads", rd_cnt, 32'd2);
    chk("fetch_0010_opc", bus.fetch_opc, 32'hA9C01234);

    // two wait states in each half
    cycle(1'b0, 16'h0000, 1'b1, 1'b0);
    cycle(1'b1, 16'h0010, 1'b0, 1'b0);
    cycle(1'b0, 16'h0000, 1'b0, 1'b0);
    cycle(1'b0, 16'h0000, 1'b0, 1'b0);
    cycle(1'b0, 16'h0000, 1'b0, 1'b1);
    cycle(1'b0, 16'h0000, 1'b0, 1'b0);
    cycle(1'b0, 16'h0000, 1'b0, 1'b0);
    cycle(1'b0, 16'h0000, 1'b0, 1'b1);
    idle(1, 1'b1);
    chk("wait_opc", bus.fetch_opc, 32'hA9C01234);

    // flush during the low-half read, then refetch
    cycle(1'b1, 16'h0020, 1'b0, 1'b1);
    cycle(1'b0, 16'h0000, 1'b0, 1'b1);
    cycle(1'b0, 16'h0000, 1'b1, 1'b1);
    idle(2, 1'b1);
    rd_cnt = 0;
    cycle(1'b1, 16'h0020, 1'b0, 1'b1);
    idle(3, 1'b1);
    chk("refetch_reads", rd_cnt, 32'd2);

    // top-of-memory wrap
    saw_zero = 1'b0;
    cycle(1'b1, 16'hFFFE, 1'b0, 1'b1);
    idle(3, 1'b1);
    chk("wrap_no_zero", {31'd0, saw_zero}, 32'd0);

    // re-request of the last word
    cycle(1'b0, 16'h0000, 1'b1, 1'b0);
    cycle(1'b1, 16'h0010, 1'b0, 1'b1);
    idle(3, 1'b1);
    rd_cnt = 0;
    cycle(1'b1, 16'h0010, 1'b0, 1'b1);
    idle(3, 1'b1);
    chk("rereq_reads", rd_cnt, HIT_EN ? 32'd0 : 32'd2);
    chk("rereq_opc", bus.fetch_opc, 32'hA9C01234);

    // reset in the middle of a fetch
    cycle(1'b1, 16'h0040, 1'b0, 1'b0);
    do_reset();
    cycle(1'b1, 16'h0044, 1'b0, 1'b1);
    idle(3, 1'b1);

    // random traffic
    for (int unsigned i = 0; i < 3000; i++) begin
      logic [15:0] pc;
      if ($urandom_range(0, 3) != 0)
        pc = {12'h001, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3))};
      else
        pc = 16'($urandom);
      cycle(($urandom_range(0, 1) == 1), pc, ($urandom_range(0, 15) == 0),
            ($urandom_range(0, 9) < 7));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
